// File: rtl/ctr_m_if.sv
// ctr_m_if: E->M control fields in, M-stage decode out, plus W-stage
// destination used for store-data forwarding.
interface ctr_m_if;
  logic [5:0] op_23;
  logic [5:0] func_23;
  logic [4:0] rt_23;
  logic [4:0] rd_23;
  logic       RegWr_E;
  logic       flush_M;
  logic [4:0] A3_W;
  logic       RegWr_W;
  logic [5:0] op_34;
  logic [5:0] func_34;
  logic [4:0] rt_34;
  logic       RegWr_M;
  logic [4:0] A3_M;
  logic       MemWr_M;
  logic [1:0] Tnew_M;
  logic       MFRTM;
  modport master (
    output op_23, func_23, rt_23, rd_23, RegWr_E, flush_M, A3_W, RegWr_W,
    input  op_34, func_34, rt_34, RegWr_M, A3_M, MemWr_M, Tnew_M, MFRTM
  );
  modport slave (
    input  op_23, func_23, rt_23, rd_23, RegWr_E, flush_M, A3_W, RegWr_W,
    output op_34, func_34, rt_34, RegWr_M, A3_M, MemWr_M, Tnew_M, MFRTM
  );
endinterface

// File: rtl/ctr_m.sv
// ctr_m: MIPS M-stage controller; E->M control register plus M-stage decode.
module ctr_m (
  input logic     clk,
  input logic     reset,
  ctr_m_if.slave  bus
);
  logic [5:0] op_q, op_d, func_q, func_d;
  logic [4:0] rt_q, rt_d, rd_q, rd_d;
  logic       regwr_q, regwr_d;
  logic       is_r, addu, subu, ori, lui, lw, sw, jal;
  logic [4:0] a3;
  always_comb begin
    op_d    = bus.op_23;
    func_d  = bus.func_23;
    rt_d    = bus.rt_23;
    rd_d    = bus.rd_23;
    regwr_d = bus.RegWr_E;
  end
  // reset and flush both load a bubble (all-zero fields)
  always_ff @(posedge clk) begin
    if (reset || bus.flush_M) begin
      op_q    <= '0;
      func_q  <= '0;
      rt_q    <= '0;
      rd_q    <= '0;
      regwr_q <= 1'b0;
    end else begin
      op_q    <= op_d;
      func_q  <= func_d;
      rt_q    <= rt_d;
      rd_q    <= rd_d;
      regwr_q <= regwr_d;
    end
  end
  always_comb begin
    is_r = op_q == 6'b000000;
    addu = is_r && func_q == 6'b100001;
    subu = is_r && func_q == 6'b100011;
    ori  = op_q == 6'b001101;
    lui  = op_q == 6'b001111;
    lw   = op_q == 6'b100011;
    sw   = op_q == 6'b101011;
    jal  = op_q == 6'b000011;
    a3   = (addu || subu) ? rd_q :
           (ori || lui || lw) ? rt_q :
           jal ? 5'd31 : 5'd0;
  end
  assign bus.op_34   = op_q;
  assign bus.func_34 = func_q;
  assign bus.rt_34   = rt_q;
  assign bus.A3_M    = a3;
  assign bus.RegWr_M = regwr_q && (a3 != 5'd0);
  assign bus.MemWr_M = sw;
  assign bus.Tnew_M  = lw ? 2'b01 : 2'b00;
  assign bus.MFRTM   = sw && (rt_q != 5'd0) && bus.RegWr_W && (bus.A3_W == rt_q);
endmodule

// File: tb/tb_ctr_m.sv
// tb_ctr_m: scoreboard bench for ctr_m with a mnemonic-level reference model.
module tb_ctr_m;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  ctr_m_if bus();
  ctr_m dut (.clk(clk), .reset(reset), .bus(bus));
  typedef struct packed {
    logic [5:0] op;
    logic [5:0] func;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       rw;
  } m_t;
  typedef struct packed {
    logic [5:0] op;
    logic [5:0] func;
    logic [4:0] rt;
    logic       regwr;
    logic [4:0] a3;
    logic       memwr;
    logic [1:0] tnew;
    logic       mfrtm;
  } o_t;
  typedef enum {NONE, ADDU, SUBU, ORI, LUI, LW, SW, BEQ, J, JAL, JR} mn_t;
  o_t q[$];
  m_t m;
  int errors = 0;
  int checks = 0;
  function automatic mn_t mnem(input m_t s);
    case (s.op)
      6'h00: return s.func == 6'h21 ? ADDU : s.func == 6'h23 ? SUBU :
                    s.func == 6'h08 ? JR : NONE;
      6'h0d: return ORI;
      6'h0f: return LUI;
      6'h23: return LW;
      6'h2b: return SW;
      6'h04: return BEQ;
      6'h02: return J;
      6'h03: return JAL;
      default: return NONE;
    endcase
  endfunction
  function automatic o_t model(input m_t s, input logic [4:0] a3w, input logic rww);
    o_t o;
    mn_t k = mnem(s);
    o.op    = s.op;
    o.func  = s.func;
    o.rt    = s.rt;
    o.a3    = (k == ADDU || k == SUBU) ? s.rd :
              (k == ORI || k == LUI || k == LW) ? s.rt :
              (k == JAL) ? 5'd31 : 5'd0;
    o.regwr = s.rw && o.a3 != 0;
    o.memwr = k == SW;
    o.tnew  = k == LW ? 2'd1 : 2'd0;
    o.mfrtm = k == SW && s.rt != 0 && rww && a3w == s.rt;
    return o;
  endfunction
  task automatic cyc(input logic [5:0] op, input logic [5:0] func, input logic [4:0] rt,
                     input logic [4:0] rd, input logic rw, input logic fl, input logic rs,
                     input logic [4:0] a3w, input logic rww);
    bus.op_23 = op;
    bus.func_23 = func;
    bus.rt_23 = rt;
    bus.rd_23 = rd;
    bus.RegWr_E = rw;
    bus.flush_M = fl;
    reset = rs;
    @(posedge clk);
    m = (rs || fl) ? '0 : {op, func, rt, rd, rw};
    #1;
    bus.A3_W = a3w;
    bus.RegWr_W = rww;
    q.push_back(model(m, a3w, rww));
  endtask
  initial begin
    o_t e, a;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        a = {bus.op_34, bus.func_34, bus.rt_34, bus.RegWr_M, bus.A3_M,
             bus.MemWr_M, bus.Tnew_M, bus.MFRTM};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL out#%0d {op,func,rt,rw,a3,mw,tnew,mfrtm}: got %h want %h", checks, a, e);
        end
      end
    end
  end
  initial begin
    logic [5:0] ops [12];
    logic [5:0] op, func;
    logic [4:0] rt;
    ops = '{6'h00, 6'h00, 6'h00, 6'h0d, 6'h0f, 6'h23, 6'h2b, 6'h2b, 6'h04, 6'h02, 6'h03, 6'h3f};
    bus.A3_W = 0;
    bus.RegWr_W = 0;
    cyc(6'h23, 6'h00, 5'd5, 5'd0, 1, 0, 1, 0, 0);
    cyc(6'h23, 6'h00, 5'd5, 5'd0, 1, 0, 1, 0, 0);
    cyc(6'h23, 6'h00, 5'd5, 5'd0, 1, 0, 0, 0, 0);
    cyc(6'h00, 6'h21, 5'd1, 5'd9, 1, 0, 0, 0, 0);
    cyc(6'h0d, 6'h00, 5'd7, 5'd0, 1, 0, 0, 0, 0);
    cyc(6'h03, 6'h00, 5'd0, 5'd0, 1, 0, 0, 0, 0);
    cyc(6'h2b, 6'h00, 5'd8, 5'd0, 0, 0, 0, 5'd8, 1);
    cyc(6'h2b, 6'h00, 5'd8, 5'd0, 0, 0, 0, 5'd8, 0);
    cyc(6'h2b, 6'h00, 5'd0, 5'd0, 0, 0, 0, 5'd0, 1);
    cyc(6'h23, 6'h00, 5'd0, 5'd0, 1, 0, 0, 0, 0);
    cyc(6'h2b, 6'h00, 5'd8, 5'd0, 0, 1, 0, 5'd8, 1);
    cyc(6'h00, 6'h23, 5'd2, 5'd4, 1, 0, 0, 0, 0);
    cyc(6'h3f, 6'h00, 5'd3, 5'd3, 1, 0, 0, 0, 0);
    cyc(6'h2b, 6'h00, 5'd6, 5'd0, 1, 1, 1, 5'd6, 1);
    cyc(6'h00, 6'h08, 5'd6, 5'd6, 1, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      op = ops[$urandom_range(0, 11)];
      if ($urandom_range(0, 9) == 0) op = 6'($urandom);
      func = op == 0 ? ($urandom_range(0, 3) == 0 ? 6'($urandom) :
                        $urandom_range(0, 2) == 0 ? 6'h08 :
                        $urandom_range(0, 1) == 0 ? 6'h21 : 6'h23) : 6'($urandom);
      rt = $urandom_range(0, 7) == 0 ? 5'd0 : 5'($urandom);
      cyc(op, func, rt, 5'($urandom), 1'($urandom), $urandom_range(0, 9) == 0,
          $urandom_range(0, 29) == 0, $urandom_range(0, 1) ? rt : 5'($urandom), 1'($urandom));
    end
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      errors++;
      checks++;
      $display("FAIL drain: %0d outputs never checked, want 0", q.size());
    end
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ctr_m.md
# ctr_m

Memory-stage controller for the five-stage MIPS pipeline (addu, subu, ori, lui, lw, sw, beq, j, jal, jr). It holds the E→M pipeline register for control fields and decodes the M-stage instruction. It drives data-memory write enable, the M-stage destination register, Tnew_M for the hazard unit, and the store-data forwarding select. Its outputs op_34, func_34 and RegWr_M are the inputs the W-stage controller registers on the next edge.

## Interface
Parameters: none.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; clears the M-stage register to a bubble
- op_23  input  6  opcode of instruction leaving E
- func_23  input  6  funct field of instruction leaving E
- rt_23  input  5  rt field of instruction leaving E
- rd_23  input  5  rd field of instruction leaving E
- RegWr_E  input  1  E-stage register-write enable
- flush_M  input  1  replace the incoming instruction with a bubble this edge
- A3_W  input  5  destination register of the W-stage instruction
- RegWr_W  input  1  W-stage register-write enable
- op_34  output  6  registered M-stage opcode
- func_34  output  6  registered M-stage funct
- rt_34  output  5  registered M-stage rt
- RegWr_M  output  1  registered M-stage register-write enable; forced 0 when A3_M = 0
- A3_M  output  5  M-stage destination register
- MemWr_M  output  1  data-memory write enable
- Tnew_M  output  2  cycles until the M-stage result is available
- MFRTM  output  1  store-data select: 0 = rt value carried from E, 1 = W-stage write-back value

## Operation
- The state register holds {op, func, rt, rd, regwr}. Every rising edge:
  - If reset or flush_M is high, the register loads all zeros. This is a bubble: op 0, func 0, which decodes as none of the supported instructions.
  - Otherwise the register loads {op_23, func_23, rt_23, rd_23, RegWr_E}.
- Instruction decode is combinational from the register, using the shared decoder: addu/subu are op 000000 with funct 100001/100011; ori 001101; lui 001111; lw 100011; sw 101011; beq 000100; j 000010; jal 000011; jr is op 000000 with funct 001000.
- A3_M:
  - rd for addu/subu
  - rt for ori/lui/lw
  - 5'd31 for jal
  - 0 for all other instructions, including the bubble
- RegWr_M = registered regwr AND (A3_M != 0). A write to $0 is never reported.
- MemWr_M = sw.
- Tnew_M:
  - 2'b01 for lw (data comes out of DM at the end of M)
  - 2'b00 for all other instructions
- MFRTM = 1 only when sw AND rt_34 != 0 AND RegWr_W AND A3_W == rt_34. Otherwise 0.
- Unrecognised encodings behave as a bubble: A3_M = 0, RegWr_M = 0, MemWr_M = 0, Tnew_M = 0, MFRTM = 0.

## Timing
- Latency: an instruction presented on the *_23 inputs before edge N appears on every output after edge N. Outputs are valid for exactly one cycle.
- Outputs are combinational from the register plus A3_W/RegWr_W. No input *_23 reaches any output in the same cycle.
- Reset value of all outputs: op_34 = 0, func_34 = 0, rt_34 = 0, RegWr_M = 0, A3_M = 0, MemWr_M = 0, Tnew_M = 0, MFRTM = 0.
- Reset mid-operation: the instruction in M is discarded at that edge with no DM write and no register write. A bubble propagates to W on the following edge.
- reset and flush_M high together: a single bubble is loaded, identical to reset alone.
- There is no stall input. The M stage always advances, and the hazard unit stalls only F/D.
- MFRTM is re-evaluated whenever A3_W/RegWr_W change within a cycle; it has no registered delay.

## Test plan
- **Reset:** hold reset for 2 cycles while feeding lw on the *_23 inputs. Required: all outputs 0, MemWr_M = 0. After release, lw $5 (rt = 5) → next cycle A3_M = 5, RegWr_M = 1, Tnew_M = 01.
- **Destination select:** feed addu rd = 9, ori rt = 7, jal, and sw back-to-back with RegWr_E high for the first three. Required: A3_M = 9, 7, 31, 0 on consecutive cycles; RegWr_M = 1, 1, 1, 0; MemWr_M = 1 only on the sw cycle.
- **$0 suppression:** feed lw with rt = 0 and RegWr_E = 1. Required: A3_M = 0, RegWr_M = 0, Tnew_M = 01.
- **Store forwarding:** sw rt = 8 in M with A3_W = 8 and RegWr_W = 1. Required: MFRTM = 1.
  - A3_W = 8 with RegWr_W = 0 → MFRTM = 0.
  - rt = 0 with A3_W = 0 and RegWr_W = 1 → MFRTM = 0.
- **Flush:** assert flush_M while sw is on the *_23 inputs. Required: next cycle MemWr_M = 0, op_34 = 0, func_34 = 0. The instruction after it latches normally.
- **Unknown opcode:** feed op 111111 with RegWr_E = 1 and rd = 3. Required: A3_M = 0, RegWr_M = 0, MemWr_M = 0, Tnew_M = 0.
